// File: rtl/display_arbiter.sv
// Round-robin arbiter that hands a 7-segment display to one of four requesters
// and keeps each granted word on screen for at least HOLD_CYCLES clocks.
module display_arbiter #(
   parameter int unsigned HOLD_CYCLES = 12500,
   parameter int unsigned CNT_W       = 16,
   parameter logic [15:0] IDLE_VALUE  = 16'h0000
) (
   input  logic        gclock,
   input  logic        greset,
   input  logic [3:0]  req,
   input  logic [63:0] reqData,
   output logic [15:0] dataOut,
   output logic [3:0]  gnt,
   output logic [1:0]  owner,
   output logic        busy
);

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      data_d;
   logic [3:0]       gnt_d;
   logic [1:0]       owner_d;
   logic             busy_d;
   logic             rst_q;
   logic             win_found;
   logic [1:0]       win_idx;
   logic [15:0]      win_word;
   logic [15:0]      owner_word;

   // Scan owner+1, owner+2, owner+3, owner; the current owner is always last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = owner;
      for (int k = 1; k <= 4; k++) begin
         if (!win_found && req[2'(owner + 2'(k))]) begin
            win_found = 1'b1;
            win_idx   = 2'(owner + 2'(k));
         end
      end
   end

   assign win_word   = reqData[{win_idx, 4'b0000} +: 16];
   assign owner_word = reqData[{owner, 4'b0000} +: 16];

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      data_d  = dataOut;
      gnt_d   = '0;
      owner_d = owner;

      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = HOLD;
               cnt_d   = '0;
               data_d  = win_word;
               owner_d = win_idx;
               gnt_d   = 4'b0001 << win_idx;
            end
         end
         HOLD: begin
            if (req[owner])
               data_d = owner_word;
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end else if (win_found && (win_idx != owner)) begin
               cnt_d   = '0;
               data_d  = win_word;
               owner_d = win_idx;
               gnt_d   = 4'b0001 << win_idx;
            end else if (!win_found) begin
               state_d = IDLE;
            end
         end
      endcase

      // The first edge after reset release only arms rst_q; nothing else may move.
      if (!rst_q) begin
         state_d = IDLE;
         cnt_d   = '0;
         data_d  = IDLE_VALUE;
         gnt_d   = '0;
         owner_d = '0;
      end

      busy_d = (state_d == HOLD);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge gclock or negedge greset) begin
      if (!greset) begin
         rst_q   <= 1'b0;
         state_q <= IDLE;
         cnt_q   <= '0;
         dataOut <= IDLE_VALUE;
         gnt     <= '0;
         owner   <= '0;
         busy    <= 1'b0;
      end else begin
         rst_q   <= 1'b1;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dataOut <= data_d;
         gnt     <= gnt_d;
         owner   <= owner_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter: two instances (hold 4 and hold 1) checked every cycle
// against an elapsed-time model, plus directed literal expectations.
module tb_display_arbiter;

   logic        gclock;
   logic        greset;
   logic [3:0]  req;
   logic [63:0] reqData;

   logic [15:0] d4_data, d1_data;
   logic [3:0]  d4_gnt, d1_gnt;
   logic [1:0]  d4_owner, d1_owner;
   logic        d4_busy, d1_busy;

   int n_checks = 0;
   int n_errors = 0;

   display_arbiter #(.HOLD_CYCLES(4), .CNT_W(16), .IDLE_VALUE(16'h0000)) dut4 (
      .gclock(gclock), .greset(greset), .req(req), .reqData(reqData),
      .dataOut(d4_data), .gnt(d4_gnt), .owner(d4_owner), .busy(d4_busy)
   );

   display_arbiter #(.HOLD_CYCLES(1), .CNT_W(16), .IDLE_VALUE(16'h0000)) dut1 (
      .gclock(gclock), .greset(greset), .req(req), .reqData(reqData),
      .dataOut(d1_data), .gnt(d1_gnt), .owner(d1_owner), .busy(d1_busy)
   );

   initial gclock = 1'b0;
   always #5 gclock = ~gclock;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model (index 0: hold 4, index 1: hold 1)
   logic [15:0] m_data  [2] = '{16'h0000, 16'h0000};
   logic [3:0]  m_gnt   [2] = '{4'h0, 4'h0};
   logic [1:0]  m_owner [2] = '{2'd0, 2'd0};
   logic        m_busy  [2] = '{1'b0, 1'b0};
   logic        m_armed [2] = '{1'b0, 1'b0};
   int          m_since [2] = '{0, 0};

   function automatic int hold_of(input int j);
      return (j == 0) ? 4 : 1;
   endfunction

   function automatic logic [15:0] word_of(input int i);
      return reqData[16*i +: 16];
   endfunction

   function automatic int rr_pick(input logic [1:0] last, input logic [3:0] mask);
      for (int k = 1; k <= 4; k++) begin
         int idx;
         idx = (int'(last) + k) % 4;
         if (mask[idx]) return idx;
      end
      return -1;
   endfunction

   task automatic model_grant(input int j, input int w);
      m_owner[j] = 2'(w);
      m_data[j]  = word_of(w);
      m_gnt[j]   = 4'(1 << w);
      m_busy[j]  = 1'b1;
      m_since[j] = 0;
   endtask

   task automatic model_edge(input int j);
      logic [3:0] others;
      m_gnt[j] = 4'h0;
      if (!m_armed[j]) begin
         m_armed[j] = 1'b1;
         return;
      end
      if (!m_busy[j]) begin
         if (req != 4'h0) model_grant(j, rr_pick(m_owner[j], req));
         return;
      end
      if (req[m_owner[j]]) m_data[j] = word_of(int'(m_owner[j]));
      if (m_since[j] >= hold_of(j) - 1) begin
         others = req;
         others[m_owner[j]] = 1'b0;
         if (others != 4'h0) begin
            model_grant(j, rr_pick(m_owner[j], others));
            return;
         end
         if (req == 4'h0) m_busy[j] = 1'b0;
      end
      m_since[j]++;
   endtask

   always @(posedge gclock or negedge greset) begin
      for (int j = 0; j < 2; j++) begin
         if (!greset) begin
            m_data[j]  = 16'h0000;
            m_gnt[j]   = 4'h0;
            m_owner[j] = 2'd0;
            m_busy[j]  = 1'b0;
            m_armed[j] = 1'b0;
            m_since[j] = 0;
         end else begin
            model_edge(j);
         end
      end
   end

   // ---------------- per-cycle comparison against the model
   always @(negedge gclock) begin
      check("h4_data",  d4_data,         m_data[0]);
      check("h4_gnt",   16'(d4_gnt),     16'(m_gnt[0]));
      check("h4_owner", 16'(d4_owner),   16'(m_owner[0]));
      check("h4_busy",  16'(d4_busy),    16'(m_busy[0]));
      check("h1_data",  d1_data,         m_data[1]);
      check("h1_gnt",   16'(d1_gnt),     16'(m_gnt[1]));
      check("h1_owner", 16'(d1_owner),   16'(m_owner[1]));
      check("h1_busy",  16'(d1_busy),    16'(m_busy[1]));
   end

   // ---------------- directed stimulus with literal expectations
   task automatic tick();
      @(negedge gclock);
   endtask

   task automatic set_word(input int i, input logic [15:0] w);
      reqData[16*i +: 16] = w;
   endtask

   task automatic pulse_reset(input logic [3:0] r);
      greset = 1'b0;
      tick();
      req    = r;
      greset = 1'b1;
   endtask

   task automatic expect4(input string name, input logic [3:0] g, input logic [1:0] o,
                          input logic [15:0] d, input logic b);
      check({name, "_gnt"},   16'(d4_gnt),   16'(g));
      check({name, "_owner"}, 16'(d4_owner), 16'(o));
      check({name, "_data"},  d4_data,       d);
      check({name, "_busy"},  16'(d4_busy),  16'(b));
   endtask

   logic [1:0]  rr_order [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
   logic [15:0] words    [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

   initial begin
      greset  = 1'b0;
      req     = 4'h0;
      reqData = '0;
      repeat (2) tick();
      expect4("reset", 4'h0, 2'd0, 16'h0000, 1'b0);

      // release with a request already present: first edge is absorbed
      req = 4'b0001;
      set_word(0, 16'h1234);
      greset = 1'b1;
      tick();
      expect4("release_edge1", 4'h0, 2'd0, 16'h0000, 1'b0);
      tick();
      expect4("first_grant", 4'b0001, 2'd0, 16'h1234, 1'b1);

      // owner alone keeps the display, counter saturates, no new grant
      set_word(0, 16'h4321);
      repeat (6) tick();
      expect4("owner_only", 4'h0, 2'd0, 16'h4321, 1'b1);
      req = 4'h0;
      tick();
      expect4("sat_to_idle", 4'h0, 2'd0, 16'h4321, 1'b0);
      tick();
      expect4("idle_hold", 4'h0, 2'd0, 16'h4321, 1'b0);

      // all four requesting: rotation 1,2,3,0,1 every 4 cycles
      for (int i = 0; i < 4; i++) set_word(i, words[i]);
      pulse_reset(4'b1111);
      tick();
      for (int g = 0; g < 5; g++) begin
         tick();
         expect4("rr_grant", 4'(1 << rr_order[g]), rr_order[g], words[rr_order[g]], 1'b1);
         if (g < 4) begin
            repeat (3) begin
               tick();
               check("rr_gap_gnt", 16'(d4_gnt), 16'h0000);
            end
         end
      end
      req = 4'h0;
      repeat (5) tick();

      // owner 2 drops at once; a brief req[0] before eligibility is lost
      set_word(2, 16'h5678);
      req = 4'b0100;
      tick();
      expect4("own2_grant", 4'b0100, 2'd2, 16'h5678, 1'b1);
      req = 4'b0001;
      set_word(2, 16'h9999);
      tick();
      expect4("own2_c1", 4'h0, 2'd2, 16'h5678, 1'b1);
      req = 4'h0;
      repeat (2) tick();
      expect4("own2_c3", 4'h0, 2'd2, 16'h5678, 1'b1);
      tick();
      expect4("own2_c4", 4'h0, 2'd2, 16'h5678, 1'b0);
      tick();
      expect4("own2_idle", 4'h0, 2'd2, 16'h5678, 1'b0);

      // owner 0 tracks a changing word; req[3] waits for eligibility
      set_word(0, 16'h0001);
      req = 4'b0001;
      tick();
      expect4("trk_grant", 4'b0001, 2'd0, 16'h0001, 1'b1);
      set_word(0, 16'h0002);
      set_word(3, 16'hD00D);
      req = 4'b1001;
      tick();
      expect4("trk_c1", 4'h0, 2'd0, 16'h0002, 1'b1);
      repeat (2) tick();
      expect4("trk_c3", 4'h0, 2'd0, 16'h0002, 1'b1);
      tick();
      expect4("trk_c4", 4'b1000, 2'd3, 16'hD00D, 1'b1);
      req = 4'h0;
      repeat (5) tick();

      // asynchronous reset in the middle of owner 1's hold
      req = 4'b0010;
      tick();
      expect4("mid_grant", 4'b0010, 2'd1, 16'hBBBB, 1'b1);
      tick();
      #2 greset = 1'b0;
      #1 expect4("async_rst", 4'h0, 2'd0, 16'h0000, 1'b0);
      req = 4'b0011;
      tick();
      greset = 1'b1;
      tick();
      expect4("rst_edge1", 4'h0, 2'd0, 16'h0000, 1'b0);
      tick();
      expect4("rst_regrant", 4'b0010, 2'd1, 16'hBBBB, 1'b1);
      req = 4'h0;
      repeat (5) tick();

      // hold of one cycle: 0100 and 0001 alternate every cycle
      pulse_reset(4'b0101);
      tick();
      for (int k = 0; k < 6; k++) begin
         tick();
         check("h1_alt_gnt",   16'(d1_gnt),   (k % 2 == 0) ? 16'h0004 : 16'h0001);
         check("h1_alt_owner", 16'(d1_owner), (k % 2 == 0) ? 16'h0002 : 16'h0000);
      end
      req = 4'h0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
